divide_controller: RTL and testbench
====================================

DIVIDE_CONTROLLER -- requirements
Module: divide_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and quotient width.
REQ-002 SHALL have parameter TIMEOUT, default WIDTH+4, maximum WAIT cycles before abort.
REQ-003 clock  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 requestValid  in  1  upstream offers a divide operation.
REQ-006 requestReady  out  1  controller can accept a request.
REQ-007 dividend, divider  in  WIDTH each  signed two's-complement operands.
REQ-008 divStart  out  1  start pulse to the divider datapath.
REQ-009 divDividend, divDivider  out  WIDTH each  registered operands to the datapath.
REQ-010 divQuotient  in  WIDTH  quotient from the datapath.
REQ-011 divReady  in  1  datapath idle/done indication.
REQ-012 resultValid  out  1  result available downstream.
REQ-013 resultAccept  in  1  downstream consumes the result.
REQ-014 quotient  out  WIDTH  registered result.
REQ-015 divideByZero, overflow, timeout  out  1 each  status flags qualified by resultValid.

Function
REQ-016 SHALL implement states IDLE, ISSUE, WAIT, DONE; requestReady=1 only in IDLE.
REQ-017 IDLE: on requestValid, SHALL latch both operands into divDividend/divDivider and clear all flags.
REQ-018 IDLE, divider==0: SHALL go to DONE with quotient={WIDTH{1}}, divideByZero=1, datapath not started.
REQ-019 IDLE, dividend==MIN (1 followed by WIDTH-1 zeros) and divider=={WIDTH{1}}: SHALL go to DONE with quotient=MIN, overflow=1, datapath not started.
REQ-020 IDLE, all other requests: SHALL go to ISSUE.
REQ-021 ISSUE: divStart=1 for exactly one cycle, then SHALL go to WAIT; divStart=0 in every other state.
REQ-022 WAIT: divReady in the first WAIT cycle SHALL be ignored; stale ready from a prior operation never completes a request.
REQ-023 WAIT: from the second cycle, divReady=1 SHALL capture divQuotient into quotient and go to DONE.
REQ-024 WAIT: a cycle counter SHALL abort to DONE with timeout=1 and quotient=0 when it reaches TIMEOUT without divReady.
REQ-025 divDividend/divDivider SHALL remain stable from ISSUE until the next IDLE acceptance.
REQ-026 DONE: resultValid=1; quotient and flags SHALL hold while resultAccept=0; resultAccept=1 SHALL return the block to IDLE.
REQ-027 A new request SHALL be accepted no earlier than the cycle after the DONE->IDLE transition.
REQ-028 Latency: normal request SHALL assert resultValid WIDTH+2 cycles after the accepting edge; special cases (REQ-018/019) 1 cycle after.
REQ-029 At most one divide operation SHALL be in flight; requestValid outside IDLE SHALL be ignored.

Reset
REQ-030 reset=0 SHALL immediately force IDLE, independent of clock.
REQ-031 During and after reset: requestReady=1; divStart, resultValid, quotient, flags, divDividend, divDivider, and WAIT counter all 0.
REQ-032 Reset mid-operation SHALL discard the in-flight result; the datapath is not reset, and the next ISSUE restarts it because start has priority.

Verification
REQ-033 WIDTH=32, 100/7 -> quotient 14, flags 0, resultValid exactly 34 cycles after acceptance.
REQ-034 -100/7 -> quotient 0xFFFFFFF2; 0x80000000/0xFFFFFFFF -> quotient 0x80000000, overflow=1, resultValid after 1 cycle, no divStart.
REQ-035 5/0 -> quotient 0xFFFFFFFF, divideByZero=1, resultValid after 1 cycle, divStart never asserted.
REQ-036 Hold resultAccept=0 for 10 cycles in DONE -> quotient and flags constant, requestReady=0, extra requestValid ignored.
REQ-037 reset pulsed low in WAIT, then 9/3 -> resultValid never asserted for the aborted op; new quotient 3.
REQ-038 divReady forced 0 after ISSUE -> timeout=1 and quotient 0 after TIMEOUT WAIT cycles; divReady forced 1 -> first WAIT cycle ignored.

Source files
------------

// File: rtl/divide_controller.sv
// Sequencing controller for an external signed divider datapath.
// Special cases are resolved locally, and a watchdog bounds every datapath run.
module divide_controller #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = WIDTH + 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             requestValid,
    output logic             requestReady,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divider,
    output logic             divStart,
    output logic [WIDTH-1:0] divDividend,
    output logic [WIDTH-1:0] divDivider,
    input  logic [WIDTH-1:0] divQuotient,
    input  logic             divReady,
    output logic             resultValid,
    input  logic             resultAccept,
    output logic [WIDTH-1:0] quotient,
    output logic             divideByZero,
    output logic             overflow,
    output logic             timeout
);

    localparam int              CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   LAST     = CW'(TIMEOUT - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state, next_state;
    logic [CW-1:0]    wait_cnt, next_cnt;
    logic [WIDTH-1:0] next_quot;
    logic             next_dbz, next_ovf, next_to;
    logic             load_ops;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            quotient     <= '0;
            divideByZero <= 1'b0;
            overflow     <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state        <= next_state;
            wait_cnt     <= next_cnt;
            quotient     <= next_quot;
            divideByZero <= next_dbz;
            overflow     <= next_ovf;
            timeout      <= next_to;
        end
    end

    // Operands stay frozen from acceptance until the next request is taken.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            divDividend <= '0;
            divDivider  <= '0;
        end else if (load_ops) begin
            divDividend <= dividend;
            divDivider  <= divider;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = wait_cnt;
        next_quot  = quotient;
        next_dbz   = divideByZero;
        next_ovf   = overflow;
        next_to    = timeout;
        load_ops   = 1'b0;
        case (state)
            IDLE: begin
                if (requestValid) begin
                    load_ops  = 1'b1;
                    next_quot = '0;
                    next_dbz  = 1'b0;
                    next_ovf  = 1'b0;
                    next_to   = 1'b0;
                    if (divider == '0) begin
                        next_quot  = ONES;
                        next_dbz   = 1'b1;
                        next_state = DONE;
                    end else if (dividend == MIN_VAL && divider == ONES) begin
                        next_quot  = MIN_VAL;
                        next_ovf   = 1'b1;
                        next_state = DONE;
                    end else begin
                        next_state = ISSUE;
                    end
                end
            end
            ISSUE: begin
                next_cnt   = '0;
                next_state = WAIT;
            end
            WAIT: begin
                // Ready in the first WAIT cycle may be left over from an earlier run.
                if (wait_cnt != '0 && divReady) begin
                    next_quot  = divQuotient;
                    next_state = DONE;
                end else if (wait_cnt == LAST) begin
                    next_quot  = '0;
                    next_to    = 1'b1;
                    next_state = DONE;
                end else begin
                    next_cnt = wait_cnt + 1'b1;
                end
            end
            DONE: begin
                next_cnt = '0;
                if (resultAccept) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign requestReady = (state == IDLE);
    assign divStart     = (state == ISSUE);
    assign resultValid  = (state == DONE);

endmodule

// File: tb/tb_divide_controller.sv
// Scoreboard bench for divide_controller with a behavioural WIDTH-cycle divider.
module tb_divide_controller;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = WIDTH + 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             requestValid, requestReady;
    logic [WIDTH-1:0] dividend, divider;
    logic             divStart;
    logic [WIDTH-1:0] divDividend, divDivider, divQuotient;
    logic             divReady;
    logic             resultValid, resultAccept;
    logic [WIDTH-1:0] quotient;
    logic             divideByZero, overflow, timeout;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             dbz;
        logic             ovf;
        logic             to;
        int               lat;
        int               starts;
    } exp_t;

    exp_t sb[$];
    int   checkCount  = 0;
    int   errorCount  = 0;
    int   start_count = 0;
    int   force_mode  = 0;
    int   dp_cnt      = 0;
    logic [WIDTH-1:0] dp_res = '0;

    divide_controller #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .requestValid(requestValid), .requestReady(requestReady),
        .dividend(dividend), .divider(divider),
        .divStart(divStart), .divDividend(divDividend), .divDivider(divDivider),
        .divQuotient(divQuotient), .divReady(divReady),
        .resultValid(resultValid), .resultAccept(resultAccept),
        .quotient(quotient), .divideByZero(divideByZero),
        .overflow(overflow), .timeout(timeout)
    );

    always #5 clock = ~clock;

    // Datapath is never reset; a start always restarts it.
    always @(posedge clock) begin
        if (divStart) begin
            start_count <= start_count + 1;
            dp_cnt      <= WIDTH;
            dp_res      <= (divDivider == '0) ? '1
                         : WIDTH'($signed(divDividend) / $signed(divDivider));
        end else if (dp_cnt != 0) begin
            dp_cnt <= dp_cnt - 1;
        end
    end

    assign divQuotient = dp_res;
    assign divReady    = (force_mode == 1) ? 1'b0 :
                         (force_mode == 2) ? 1'b1 : (dp_cnt == 0);

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input int mode);
        exp_t e;
        logic [WIDTH-1:0] min_val;
        min_val = {1'b1, {(WIDTH-1){1'b0}}};
        e.dbz = 1'b0; e.ovf = 1'b0; e.to = 1'b0;
        if (b == '0) begin
            e.q = '1; e.dbz = 1'b1; e.lat = 1; e.starts = 0;
        end else if (a == min_val && b == '1) begin
            e.q = min_val; e.ovf = 1'b1; e.lat = 1; e.starts = 0;
        end else begin
            e.starts = 1;
            e.q      = WIDTH'($signed(a) / $signed(b));
            e.lat    = WIDTH + 2;
            if (mode == 1) begin
                e.q = '0; e.to = 1'b1; e.lat = TIMEOUT + 1;
            end else if (mode == 2) begin
                e.lat = 3;
            end
        end
        return e;
    endfunction

    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input int mode, input int hold);
        exp_t e;
        int   lat;
        int   starts0;
        sb.push_back(model(a, b, mode));
        force_mode = mode;
        @(negedge clock);
        checkOutput("ready_before_req", requestReady, 1);
        dividend     = a;
        divider      = b;
        requestValid = 1'b1;
        starts0      = start_count;
        @(posedge clock);
        #1 requestValid = 1'b0;
        lat = 0;
        while (lat < 100) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            if (resultValid) break;
        end
        checkOutput("result_valid_seen", resultValid, 1);
        e = sb.pop_front();
        checkOutput("latency", lat, e.lat);
        checkOutput("quotient", quotient, e.q);
        checkOutput("flags", {divideByZero, overflow, timeout}, {e.dbz, e.ovf, e.to});
        checkOutput("start_pulses", start_count - starts0, e.starts);
        checkOutput("operands", {divDividend, divDivider}, {a, b});
        for (int i = 0; i < hold; i++) begin
            requestValid = 1'b1;
            dividend     = ~a;
            divider      = 32'd3;
            @(negedge clock);
            checkOutput("hold_quotient", quotient, e.q);
            checkOutput("hold_flags", {divideByZero, overflow, timeout}, {e.dbz, e.ovf, e.to});
            checkOutput("hold_valid_ready", {resultValid, requestReady}, 2'b10);
            checkOutput("hold_operands", {divDividend, divDivider}, {a, b});
        end
        requestValid = 1'b0;
        resultAccept = 1'b1;
        @(negedge clock);
        resultAccept = 1'b0;
        checkOutput("idle_after_accept", {requestReady, resultValid}, 2'b10);
        force_mode = 0;
    endtask

    initial begin
        logic seen;
        reset        = 1'b0;
        requestValid = 1'b0;
        resultAccept = 1'b0;
        dividend     = '0;
        divider      = '0;
        repeat (3) @(negedge clock);
        checkOutput("reset_ready", requestReady, 1);
        checkOutput("reset_ctrl", {divStart, resultValid}, 2'b00);
        checkOutput("reset_quotient", quotient, 0);
        checkOutput("reset_flags", {divideByZero, overflow, timeout}, 3'b000);
        checkOutput("reset_operands", {divDividend, divDivider}, 64'd0);
        checkOutput("reset_wait_cnt", dut.wait_cnt, 0);
        reset = 1'b1;

        applyStimulus(32'd100, 32'd7, 0, 0);
        applyStimulus(-32'sd100, 32'd7, 0, 0);
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        applyStimulus(32'd5, 32'd0, 0, 0);
        applyStimulus(32'd123, 32'd10, 0, 10);
        applyStimulus(32'h8000_0000, 32'd1, 0, 0);
        for (int i = 0; i < 4; i++)
            applyStimulus($urandom, $urandom_range(1, 5000) * ((i % 2) ? -1 : 1), 0, 0);

        // Abort an operation mid-WAIT.
        @(negedge clock);
        dividend = 32'd50; divider = 32'd5; requestValid = 1'b1;
        @(posedge clock);
        #1 requestValid = 1'b0;
        repeat (6) @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("async_reset_state", {requestReady, resultValid, divStart}, 3'b100);
        checkOutput("async_reset_quotient", quotient, 0);
        checkOutput("async_reset_operands", {divDividend, divDivider}, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        seen  = 1'b0;
        repeat (45) begin
            @(negedge clock);
            if (resultValid) seen = 1'b1;
        end
        checkOutput("aborted_never_valid", seen, 0);
        applyStimulus(32'd9, 32'd3, 0, 0);

        applyStimulus(32'd20, 32'd4, 1, 0);
        applyStimulus(32'd77, 32'd7, 2, 0);
        applyStimulus(32'd1000, 32'd9, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
